// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared defaults and state encoding for the fetch PC generator
package fetch_pc_gen_pkg;

  localparam int          ADDR_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next fetch address select with redirect capture across stalls
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  fetch_stall,
  input  logic                  trap_redirect,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic                  ex_redirect,
  input  logic [ADDR_WIDTH-1:0] ex_redirect_pc,
  input  logic                  predict_taken,
  input  logic [ADDR_WIDTH-1:0] predict_target_pc,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  pc_pred_taken,
  output logic [ADDR_WIDTH-1:0] pc_pred_target
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pend_pc, pend_next;
  logic                  valid_next;
  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_pc;

  // Trap beats execute redirect; the losing ex redirect is simply dropped.
  assign redir    = trap_redirect | ex_redirect;
  assign redir_pc = (trap_redirect ? trap_pc : ex_redirect_pc) & ALIGN_MASK;

  always_comb begin
    state_next = state;
    pend_next  = pend_pc;
    valid_next = 1'b0;
    next_pc    = pc;
    if (cpu_rst) begin
      next_pc    = RESET_PC;
      state_next = BOOT;
      pend_next  = '0;
    end else begin
      case (state)
        BOOT: begin
          next_pc    = RESET_PC;
          state_next = RUN;
          valid_next = 1'b1;
        end
        RUN: begin
          valid_next = 1'b1;
          if (redir && fetch_stall) begin
            // Re-present pc while stalled and remember where to go afterwards.
            pend_next  = redir_pc;
            state_next = HOLD_REDIR;
            valid_next = 1'b0;
          end else if (redir) begin
            next_pc = redir_pc;
          end else if (fetch_stall) begin
            next_pc = pc;
          end else if (pc_valid && predict_taken) begin
            next_pc = predict_target_pc & ALIGN_MASK;
          end else begin
            next_pc = pc + ADDR_WIDTH'(4);
          end
        end
        HOLD_REDIR: begin
          if (fetch_stall) begin
            if (redir) pend_next = redir_pc;
          end else begin
            next_pc    = redir ? redir_pc : pend_pc;
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        default: begin
          next_pc    = RESET_PC;
          state_next = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= BOOT;
      pend_pc  <= '0;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      state    <= state_next;
      pend_pc  <= pend_next;
      pc       <= next_pc;
      pc_valid <= valid_next;
    end
  end

  assign pc_pred_taken  = predict_taken & pc_valid;
  assign pc_pred_target = predict_target_pc;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen with directed vectors
module tb_fetch_pc_gen;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        fetch_stall;
  logic        trap_redirect;
  logic [31:0] trap_pc;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        predict_taken;
  logic [31:0] predict_target_pc;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_pred_taken;
  logic [31:0] pc_pred_target;

  typedef struct {
    int          idx;
    logic [31:0] e_next;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_pt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  fetch_pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .cpu_clk           (cpu_clk),
    .cpu_rst           (cpu_rst),
    .fetch_stall       (fetch_stall),
    .trap_redirect     (trap_redirect),
    .trap_pc           (trap_pc),
    .ex_redirect       (ex_redirect),
    .ex_redirect_pc    (ex_redirect_pc),
    .predict_taken     (predict_taken),
    .predict_target_pc (predict_target_pc),
    .next_pc           (next_pc),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .pc_pred_taken     (pc_pred_taken),
    .pc_pred_target    (pc_pred_target)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Apply one cycle of inputs, queue what the DUT must show during that cycle.
  task automatic step(input logic rst, input logic stall,
                      input logic trp, input logic [31:0] tpc,
                      input logic ex, input logic [31:0] epc,
                      input logic ptk, input logic [31:0] ptg,
                      input logic [31:0] e_next, input logic [31:0] e_pc,
                      input logic e_valid, input logic e_pt);
    exp_t e;
    cpu_rst           = rst;
    fetch_stall       = stall;
    trap_redirect     = trp;
    trap_pc           = tpc;
    ex_redirect       = ex;
    ex_redirect_pc    = epc;
    predict_taken     = ptk;
    predict_target_pc = ptg;
    e.idx     = vec_n;
    e.e_next  = e_next;
    e.e_pc    = e_pc;
    e.e_valid = e_valid;
    e.e_pt    = e_pt;
    exp_q.push_back(e);
    vec_n++;
    @(posedge cpu_clk);
    #1;
  endtask

  always @(negedge cpu_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (next_pc !== e.e_next) begin
        errors++;
        $display("FAIL v%0d next_pc got %h want %h", e.idx, next_pc, e.e_next);
      end
      checks++;
      if (pc !== e.e_pc) begin
        errors++;
        $display("FAIL v%0d pc got %h want %h", e.idx, pc, e.e_pc);
      end
      checks++;
      if (pc_valid !== e.e_valid) begin
        errors++;
        $display("FAIL v%0d pc_valid got %b want %b", e.idx, pc_valid, e.e_valid);
      end
      checks++;
      if (pc_pred_taken !== e.e_pt) begin
        errors++;
        $display("FAIL v%0d pc_pred_taken got %b want %b", e.idx, pc_pred_taken, e.e_pt);
      end
    end
  end

  initial begin
    int wait_cycles;
    cpu_rst = 1'b1; fetch_stall = 1'b0; trap_redirect = 1'b0; trap_pc = '0;
    ex_redirect = 1'b0; ex_redirect_pc = '0; predict_taken = 1'b0; predict_target_pc = '0;
    @(posedge cpu_clk);
    #1;
    //   rst stall trp tpc           ex  epc           ptk ptg           next          pc            v  pt
    step(1, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h0,        32'h0,        0, 0); // v0 reset
    step(0, 0, 1, 32'h500,       0, 32'h0,     0, 32'h0,     32'h0,        32'h0,        0, 0); // v1 boot ignores trap
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h4,        32'h0,        1, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h8,        32'h4,        1, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     1, 32'h100,   32'h100,      32'h8,        1, 1); // v4 predicted taken
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h104,      32'h100,      1, 0);
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h104,      32'h104,      1, 0); // v6 stall x3
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h104,      32'h104,      1, 0);
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h104,      32'h104,      1, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h108,      32'h104,      1, 0);
    step(0, 0, 1, 32'h80,        1, 32'h200,   0, 32'h0,     32'h80,       32'h108,      1, 0); // v10 trap wins
    step(0, 1, 0, 32'h0,         1, 32'h300,   0, 32'h0,     32'h80,       32'h80,       1, 0); // v11 redirect under stall
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h80,       32'h80,       0, 0);
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h80,       32'h80,       0, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h300,      32'h80,       0, 0); // v14 release pending
    step(0, 0, 0, 32'h0,         1, 32'h203,   0, 32'h0,     32'h200,      32'h300,      1, 0); // v15 misaligned
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,     0, 32'h0,     32'hFFFF_FFFC,32'h200,      1, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h0,        32'hFFFF_FFFC,1, 0); // v17 wrap
    step(0, 1, 1, 32'h400,       0, 32'h0,     0, 32'h0,     32'h0,        32'h0,        1, 0); // v18 enter hold
    step(0, 1, 0, 32'h0,         1, 32'h600,   1, 32'h900,   32'h0,        32'h0,        0, 0); // v19 overwrite pend
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h600,      32'h0,        0, 0);
    step(0, 1, 1, 32'h700,       0, 32'h0,     0, 32'h0,     32'h600,      32'h600,      1, 0); // v21 enter hold
    step(0, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h600,      32'h600,      0, 0);
    step(1, 1, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h0,        32'h600,      0, 0); // v23 reset in hold
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h0,        32'h0,        0, 0);
    step(0, 0, 0, 32'h0,         0, 32'h0,     0, 32'h0,     32'h4,        32'h0,        1, 0); // v25 0x700 dropped
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge cpu_clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage program-counter generator that sits directly upstream of the branch predictor. Each cycle it selects the next fetch address from reset, trap redirect, execute-stage mispredict redirect, stall hold, predicted-taken target or sequential `pc + 4`. It drives that address to the predictor and the instruction memory, and registers it as the current `pc`. Because the predictor read is synchronous, `next_pc` in cycle N produces a prediction aligned with `pc` in cycle N+1. The generator preserves that alignment across stalls and redirects.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `cpu_clk` in, 1: cpu clock; all state updates on its rising edge.
- `cpu_rst` in, 1: cpu reset; synchronous, active-high.
- `fetch_stall` in, 1: downstream/imem cannot accept a new address; hold current `pc`.
- `trap_redirect` in, 1: trap/exception/mret redirect request (highest priority).
- `trap_pc` in, ADDR_WIDTH: trap target.
- `ex_redirect` in, 1: execute-stage mispredict redirect.
- `ex_redirect_pc` in, ADDR_WIDTH: corrected target.
- `predict_taken` in, 1: predictor taken flag for current `pc`.
- `predict_target_pc` in, ADDR_WIDTH: predicted target for current `pc`.
- `next_pc` out, ADDR_WIDTH: combinational next fetch address, to predictor read port and imem.
- `pc` out, ADDR_WIDTH: registered current fetch address.
- `pc_valid` out, 1: `pc` is a correct-path fetch.
- `pc_pred_taken` out, 1: `predict_taken` qualified by `pc_valid`, carried down the pipe for mispredict checking.
- `pc_pred_target` out, ADDR_WIDTH: `predict_target_pc` passed through alongside `pc_pred_taken`.

## Operation
- States: BOOT, RUN, HOLD_REDIR. A pending-redirect register `pend_pc` is used in HOLD_REDIR.
- `cpu_rst` high:
  - State goes to BOOT and `pend_pc` is cleared.
  - `pc` = RESET_PC, `pc_valid` = 0.
  - `next_pc` = RESET_PC combinationally.
- BOOT, one cycle:
  - `next_pc` = RESET_PC, `pc_valid` = 0, then go to RUN.
  - Redirects and stall are ignored in BOOT.
- RUN `next_pc` priority:
  1. `trap_redirect` -> `trap_pc`.
  2. `ex_redirect` -> `ex_redirect_pc`.
  3. `fetch_stall` -> `pc`. Re-presenting `pc` makes the predictor re-read the same entry, so the prediction stays aligned.
  4. `pc_valid & predict_taken` -> `predict_target_pc`.
  5. Otherwise `pc + 4`.
- A redirect (trap or ex) together with `fetch_stall` in RUN:
  - Latch the selected target into `pend_pc`.
  - Go to HOLD_REDIR with `next_pc` = `pc`.
- HOLD_REDIR:
  - `pc_valid` = 0, because the held `pc` is wrong-path.
  - A new redirect overwrites `pend_pc` with the same priority rules.
  - While `fetch_stall` is high: `next_pc` = `pc`.
  - When `fetch_stall` is low: `next_pc` = the redirect target if a redirect is present this cycle, else `pend_pc`; then go to RUN.
- `pc_valid` next-state:
  - 1 when the cycle ends in RUN without entering HOLD_REDIR.
  - It stays 1 through a plain stall.
  - It becomes 1 for the first redirect target.
- Arithmetic and alignment:
  - All loaded targets have bits [1:0] forced to 00.
  - `pc + 4` wraps modulo 2^ADDR_WIDTH.

## Timing
- Latency: 1 cycle from `next_pc` to `pc`.
- Redirect asserted in cycle N with no stall: `pc` = target in N+1 with `pc_valid` = 1, and the prediction for the target is valid in N+1.
- A predicted-taken `pc` in cycle N gives `pc` = target in N+1; there are no bubbles.
- Redirect pulses are single-cycle. They are not required to be held through a stall; the block captures them.
- Simultaneous `trap_redirect` and `ex_redirect`: the trap wins and the ex redirect is dropped.
- `cpu_rst` asserted mid-operation, including in HOLD_REDIR: the pending redirect is discarded and the next cycle is BOOT.

## Structure
- Shared `core_defines.vh`: ADDR_WIDTH and the reset-vector default.
- Local state encoding: localparams for BOOT=2'd0, RUN=2'd1, HOLD_REDIR=2'd2.
- No sub-module. The design is a single mux/next-state block plus the `pc`, `pc_valid`, state and `pend_pc` registers.

## Test plan
- Reset release with RESET_PC = 0x0 and no stall -> BOOT cycle with `pc_valid` = 0, then `pc` = 0x0, 0x4, 0x8 with `pc_valid` = 1.
- Predictor returns taken at `pc` = 0x8 with target 0x100 -> next `pc` = 0x100; `pc_pred_taken` = 1 for the 0x8 cycle.
- `fetch_stall` for 3 cycles at `pc` = 0x104 -> `next_pc` = 0x104 each cycle; `pc` and `pc_valid` = 1 held; `pc` = 0x108 after the stall drops.
- `ex_redirect` to 0x200 and `trap_redirect` to 0x80 in the same cycle -> `pc` = 0x80 next cycle.
- `ex_redirect` to 0x300 during a stall, stall held 2 more cycles:
  - `pc_valid` = 0 while held.
  - `pc` = 0x300 with `pc_valid` = 1 the cycle after the stall drops.
- Misaligned target 0x203 -> `pc` = 0x200; `pc` = 0xFFFF_FFFC sequential -> `pc` = 0x0. `cpu_rst` during HOLD_REDIR -> `pc` = RESET_PC and the pending target is never fetched.
